// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, stage states and helpers shared by the ALU execute stage.
// Opcode constants are 32-bit so callers compare a zero-extended opcode: any
// bit set above the low four then misses every entry and falls to PASS A.
package alu_pkg;
    localparam logic [31:0] COP_ADD  = 32'd0;
    localparam logic [31:0] COP_SUB  = 32'd1;
    localparam logic [31:0] COP_AND  = 32'd2;
    localparam logic [31:0] COP_ADDI = 32'd3;
    localparam logic [31:0] COP_OR   = 32'd4;
    localparam logic [31:0] COP_XOR  = 32'd5;
    localparam logic [31:0] COP_SHL  = 32'd6;
    localparam logic [31:0] COP_SHR  = 32'd7;
    localparam logic [31:0] COP_MUL  = 32'd8;

    typedef enum logic [1:0] {EMPTY, FULL, MUL_BUSY} state_t;

    function automatic logic is_mul(input logic [31:0] cop);
        return cop == COP_MUL;
    endfunction
endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: decode-side instruction handshake and writeback-side result handshake.
// master = upstream/downstream environment, slave = the execute stage.
// Carries the stall (enable), instruction fields, in_valid/in_ready,
// and result fields with out_valid/out_ready.
interface alu_exec_stage_if #(
    parameter int WIDTH = 16,
    parameter int ADR_W = 3,
    parameter int COP_W = 4
);
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [COP_W-1:0] cop;
    logic [ADR_W-1:0] destReg_adr;
    logic             we;
    logic [ADR_W-1:0] regA_adr;
    logic [ADR_W-1:0] regB_adr;
    logic [2:0]       inst_freeBits;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             OVF;
    logic [ADR_W-1:0] destReg_adr_output;
    logic             we_output;

    modport master (
        output enable, in_valid, regA, regB, cop, destReg_adr, we, regA_adr, regB_adr,
               inst_freeBits, out_ready,
        input  in_ready, out_valid, alu_result, OVF, destReg_adr_output, we_output
    );
    modport slave (
        input  enable, in_valid, regA, regB, cop, destReg_adr, we, regA_adr, regB_adr,
               inst_freeBits, out_ready,
        output in_ready, out_valid, alu_result, OVF, destReg_adr_output, we_output
    );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add unsigned multiplier, one partial product per enabled step.
// Ports: start loads a/b and arms WIDTH steps; step_en advances one step;
// product is the 2*WIDTH accumulator; done flags the step that completes the product.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     sum;

    // The multiplier sits in the low half and is consumed LSB first while the
    // partial sum (with its carry) shifts down from the high half.
    always_comb begin
        sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
        cnt_d = cnt_q;
        b_d   = b_q;
        p_d   = p_q;
        if (start) begin
            cnt_d = CW'(WIDTH);
            b_d   = b;
            p_d   = {{WIDTH{1'b0}}, a};
        end else if (step_en && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            p_d   = {sum, p_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            b_q   <= '0;
            p_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            b_q   <= b_d;
            p_q   <= p_d;
        end
    end

    assign product = p_q;
    assign done    = step_en && cnt_q == CW'(1);
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with valid/ready handshake and iterative MUL.
// Ports: clk, reset (async, active high), bus (alu_exec_stage_if.slave) carrying
// enable, instruction fields with in_valid/in_ready, and result/OVF/dest/we with out_valid/out_ready.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADR_W = 3,
    parameter int COP_W = 4
) (
    input logic             clk,
    input logic             reset,
    alu_exec_stage_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, imm, res;
    logic [COP_W-1:0]   cop_q;
    logic [ADR_W-1:0]   dst_q;
    logic               we_q;
    logic [31:0]        op;
    logic               ready, accept, new_mul, valid, ovf, mul_done;
    logic [2*WIDTH-1:0] product;

    // Size cast zero-extends or keeps the low WIDTH bits of the immediate.
    assign imm     = WIDTH'({bus.regA_adr, bus.regB_adr, bus.inst_freeBits});
    assign ready   = bus.enable && !reset && state_q != MUL_BUSY && (state_q == EMPTY || bus.out_ready);
    assign accept  = bus.in_valid && ready;
    assign new_mul = is_mul(32'(bus.cop));
    assign valid   = state_q == FULL;
    assign op      = 32'(cop_q);

    // A dequeue is allowed even while stalled; only accepts and multiply steps need enable.
    assign state_d = accept ? (new_mul ? MUL_BUSY : FULL)
                   : (state_q == FULL && bus.out_ready) ? EMPTY
                   : (state_q == MUL_BUSY && mul_done) ? FULL
                   : state_q;

    always_comb begin
        res = a_q;
        ovf = 1'b0;
        case (op)
            COP_ADD, COP_ADDI: begin
                res = a_q + b_q;
                ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            COP_SUB: begin
                res = a_q - b_q;
                ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            COP_AND: res = a_q & b_q;
            COP_OR:  res = a_q | b_q;
            COP_XOR: res = a_q ^ b_q;
            COP_SHL: res = a_q << b_q[SW-1:0];
            COP_SHR: res = a_q >> b_q[SW-1:0];
            COP_MUL: begin
                res = product[WIDTH-1:0];
                ovf = |product[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && new_mul),
        .step_en (bus.enable && state_q == MUL_BUSY),
        .a       (bus.regA),
        .b       (bus.regB),
        .product (product),
        .done    (mul_done)
    );

    // The B operand is selected at accept so the held instruction needs no immediate fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            cop_q   <= '0;
            dst_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.regA;
                b_q   <= 32'(bus.cop) == COP_ADDI ? imm : bus.regB;
                cop_q <= bus.cop;
                dst_q <= bus.destReg_adr;
                we_q  <= bus.we;
            end
        end
    end

    assign bus.in_ready           = ready;
    assign bus.out_valid          = valid;
    assign bus.alu_result         = valid ? res : '0;
    assign bus.OVF                = valid && ovf;
    assign bus.destReg_adr_output = valid ? dst_q : '0;
    assign bus.we_output          = valid && we_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of 16-bit and 32-bit execute stage builds.
module tb_alu_exec_stage;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(16), .ADR_W(3), .COP_W(4)) b16 ();
    alu_exec_stage_if #(.WIDTH(32), .ADR_W(4), .COP_W(4)) b32 ();

    alu_exec_stage #(.WIDTH(16), .ADR_W(3), .COP_W(4)) d16 (.clk(clk), .reset(reset), .bus(b16));
    alu_exec_stage #(.WIDTH(32), .ADR_W(4), .COP_W(4)) d32 (.clk(clk), .reset(reset), .bus(b32));

    typedef struct {
        logic [31:0] res;
        bit          ovf;
        logic [3:0]  dst;
        bit          we;
    } exp_t;

    // Reference: plain integer arithmetic on the operands, w bits wide.
    function automatic void model(input int w, input int op, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned r, output bit v);
        longint unsigned m, p;
        longint half, sa, sb, s;
        m    = (64'd1 << w) - 64'd1;
        half = longint'(1) << (w - 1);
        sa   = (a >= 64'(half)) ? longint'(a) - 2 * half : longint'(a);
        sb   = (b >= 64'(half)) ? longint'(b) - 2 * half : longint'(b);
        r    = a;
        v    = 1'b0;
        case (op)
            0, 3: begin r = (a + b) & m; s = sa + sb; v = s >= half || s < -half; end
            1: begin r = (a - b) & m; s = sa - sb; v = s >= half || s < -half; end
            2: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (a << (b % 64'(w))) & m;
            7: r = a >> (b % 64'(w));
            8: begin p = a * b; r = p & m; v = (p >> w) != 0; end
            default: ;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input bit v, input int op, input logic [15:0] a, input logic [15:0] b,
                           input int dst, input bit we, input int imm);
        b16.in_valid = v;
        b16.cop      = 4'(op);
        b16.regA     = a;
        b16.regB     = b;
        b16.destReg_adr = 3'(dst);
        b16.we       = we;
        {b16.regA_adr, b16.regB_adr, b16.inst_freeBits} = 9'(imm);
    endtask

    task automatic drive32(input bit v, input int op, input logic [31:0] a, input logic [31:0] b,
                           input int dst, input bit we, input int imm);
        b32.in_valid = v;
        b32.cop      = 4'(op);
        b32.regA     = a;
        b32.regB     = b;
        b32.destReg_adr = 4'(dst);
        b32.we       = we;
        {b32.regA_adr, b32.regB_adr, b32.inst_freeBits} = 11'(imm);
    endtask

    task automatic test_reset;
        tick;
        tick;
        vectors++;
        if ({b16.in_ready, b16.out_valid, b16.OVF, b16.we_output} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {b16.in_ready, b16.out_valid, b16.OVF, b16.we_output});
        end
        vectors++;
        if ({b16.alu_result, b16.destReg_adr_output} !== 19'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0", b16.alu_result, b16.destReg_adr_output);
        end
        vectors++;
        if ({b32.in_ready, b32.out_valid, b32.alu_result} !== 34'h0) begin
            errors++;
            $display("FAIL reset_w32: got %b%b %h expected all 0", b32.in_ready, b32.out_valid, b32.alu_result);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", b16.in_ready, b16.out_valid);
        end
    endtask

    task automatic test_add_ovf;
        drive16(1, 0, 16'h7fff, 16'h0001, 5, 1, 0);
        tick;
        drive16(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({b16.out_valid, b16.alu_result, b16.OVF} !== {1'b1, 16'h8000, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got v=%b r=%h ovf=%b expected v=1 r=8000 ovf=1", b16.out_valid, b16.alu_result, b16.OVF);
        end
        vectors++;
        if ({b16.destReg_adr_output, b16.we_output} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL add_fwd: got dst=%0d we=%b expected 5 1", b16.destReg_adr_output, b16.we_output);
        end
        tick;
        vectors++;
        if ({b16.out_valid, b16.we_output} !== 2'b00) begin
            errors++;
            $display("FAIL add_dequeue: got v=%b we=%b expected 0 0", b16.out_valid, b16.we_output);
        end
    endtask

    task automatic test_addi;
        drive16(1, 3, 16'h0010, 16'hffff, 2, 0, 9'b101_010_111);
        tick;
        drive16(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({b16.out_valid, b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output} !== {1'b1, 16'h0167, 1'b0, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL addi: got v=%b r=%h ovf=%b dst=%0d we=%b expected 1 0167 0 2 0",
                     b16.out_valid, b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        longint unsigned r;
        bit v;
        for (int i = 0; i < 4; i++) begin
            int op = $urandom_range(0, 7);
            logic [15:0] a = 16'($urandom);
            logic [15:0] b = 16'($urandom);
            int imm = $urandom_range(0, 511);
            model(16, op, 64'(a), op == 3 ? 64'(imm) : 64'(b), r, v);
            drive16(1, op, a, b, i, 1, imm);
            #1;
            vectors++;
            if (b16.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, b16.in_ready);
            end
            tick;
            vectors++;
            if ({b16.out_valid, b16.alu_result, b16.OVF} !== {1'b1, r[15:0], v}) begin
                errors++;
                $display("FAIL b2b_result[%0d] op=%0d: got v=%b r=%h ovf=%b expected 1 %h %b",
                         i, op, b16.out_valid, b16.alu_result, b16.OVF, r[15:0], v);
            end
        end
        drive16(0, 0, 0, 0, 0, 0, 0);
        tick;
        vectors++;
        if (b16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", b16.out_valid);
        end
    endtask

    task automatic test_back_pressure;
        logic [15:0] av[3], bv[3], ev[3];
        longint unsigned r;
        bit v, acc;
        int idx, got;
        for (int i = 0; i < 3; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
            model(16, 0, 64'(av[i]), 64'(bv[i]), r, v);
            ev[i] = r[15:0];
        end
        b16.out_ready = 1'b0;
        drive16(1, 0, av[0], bv[0], 0, 1, 0);
        tick;
        drive16(1, 0, av[1], bv[1], 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({b16.out_valid, b16.alu_result} !== {1'b1, ev[0]}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%h expected 1 %h", k, b16.out_valid, b16.alu_result, ev[0]);
            end
            vectors++;
            if (b16.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected 0", k, b16.in_ready);
            end
            tick;
        end
        b16.out_ready = 1'b1;
        idx = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (b16.out_valid) begin
                vectors++;
                if ({b16.alu_result, b16.destReg_adr_output} !== {ev[got], 3'(got)}) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got r=%h dst=%0d expected %h %0d",
                             got, b16.alu_result, b16.destReg_adr_output, ev[got], got);
                end
                got++;
            end
            acc = b16.in_valid && b16.in_ready;
            tick;
            if (acc) begin
                idx++;
                if (idx < 3) drive16(1, 0, av[idx], bv[idx], idx, 1, 0);
                else drive16(0, 0, 0, 0, 0, 0, 0);
            end
        end
        vectors++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d results expected 3", got);
        end
        #1;
        vectors++;
        if (b16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_dup: got out_valid=%b expected 0", b16.out_valid);
        end
        drive16(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stall_full;
        drive16(1, 0, 16'd1, 16'd2, 1, 1, 0);
        tick;
        drive16(1, 2, 16'hffff, 16'hffff, 2, 1, 0);
        b16.enable = 1'b0;
        b16.out_ready = 1'b0;
        #1;
        vectors++;
        if (b16.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got %b expected 0", b16.in_ready);
        end
        tick;
        vectors++;
        if ({b16.out_valid, b16.alu_result} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b r=%h expected 1 0003", b16.out_valid, b16.alu_result);
        end
        b16.out_ready = 1'b1;
        tick;
        vectors++;
        if (b16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_dequeue: got out_valid=%b expected 0", b16.out_valid);
        end
        b16.enable = 1'b1;
        drive16(0, 0, 0, 0, 0, 0, 0);
        tick;
    endtask

    task automatic test_mul_stall;
        int c = 0;
        bit bad = 0;
        drive16(1, 8, 16'h0100, 16'h0100, 4, 1, 0);
        tick;
        drive16(0, 0, 0, 0, 0, 0, 0);
        while (!b16.out_valid && c < 40) begin
            if (b16.in_ready !== 1'b0) bad = 1;
            if (c == 4) b16.enable = 1'b0;
            if (c == 6) b16.enable = 1'b1;
            tick;
            c++;
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL mul_ready: got in_ready=1 during multiply expected 0");
        end
        vectors++;
        if (c != 18) begin
            errors++;
            $display("FAIL mul_latency: got %0d cycles expected 18", c);
        end
        vectors++;
        if ({b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output} !== {16'h0000, 1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL mul_result: got r=%h ovf=%b dst=%0d we=%b expected 0000 1 4 1",
                     b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output);
        end
        b16.enable = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_mul;
        bit bad = 0;
        drive16(1, 8, 16'd3, 16'd5, 6, 1, 0);
        tick;
        drive16(0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick;
        reset = 1'b1;
        #1;
        vectors++;
        if ({b16.in_ready, b16.out_valid, b16.OVF, b16.we_output, b16.alu_result, b16.destReg_adr_output} !== 23'h0) begin
            errors++;
            $display("FAIL rst_mul_outputs: got rdy=%b v=%b ovf=%b we=%b r=%h dst=%0d expected all 0",
                     b16.in_ready, b16.out_valid, b16.OVF, b16.we_output, b16.alu_result, b16.destReg_adr_output);
        end
        tick;
        vectors++;
        if (b16.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mul_ready: got %b expected 0", b16.in_ready);
        end
        reset = 1'b0;
        repeat (25) begin
            tick;
            if (b16.out_valid !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL rst_mul_spurious: got out_valid=1 after aborted multiply expected 0");
        end
        vectors++;
        if (b16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mul_empty: got in_ready=%b expected 1", b16.in_ready);
        end
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        bit hold = 0;
        logic [15:0] prev = '0;
        longint unsigned r;
        bit v;
        for (int c = 0; c < 400; c++) begin
            bit drain = c >= 340;
            int op = $urandom_range(0, 15);
            logic [15:0] a = 16'($urandom);
            logic [15:0] b = 16'($urandom);
            int imm = $urandom_range(0, 511);
            int dst = $urandom_range(0, 7);
            bit we = 1'($urandom);
            b16.enable = drain ? 1'b1 : ($urandom_range(0, 9) != 0);
            b16.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive16(!drain && $urandom_range(0, 2) != 0, op, a, b, dst, we, imm);
            #1;
            if (hold) begin
                vectors++;
                if (b16.alu_result !== prev) begin
                    errors++;
                    $display("FAIL rnd_hold cycle %0d: got %h expected %h", c, b16.alu_result, prev);
                end
            end
            if (b16.out_valid && b16.out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra cycle %0d: got result %h expected none", c, b16.alu_result);
                end else begin
                    e = q.pop_front();
                    if ({b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output} !== {e.res[15:0], e.ovf, e.dst[2:0], e.we}) begin
                        errors++;
                        $display("FAIL rnd_result cycle %0d: got r=%h ovf=%b dst=%0d we=%b expected %h %b %0d %b",
                                 c, b16.alu_result, b16.OVF, b16.destReg_adr_output, b16.we_output,
                                 e.res[15:0], e.ovf, e.dst, e.we);
                    end
                end
            end
            if (b16.in_valid && b16.in_ready) begin
                model(16, op, 64'(a), op == 3 ? 64'(imm) : 64'(b), r, v);
                e.res = 32'(r);
                e.ovf = v;
                e.dst = 4'(dst);
                e.we  = we;
                q.push_back(e);
            end
            hold = b16.out_valid && !b16.out_ready;
            prev = b16.alu_result;
            tick;
        end
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost: got %0d results never emitted expected 0", q.size());
        end
    endtask

    task automatic test_wide;
        int c = 0;
        longint unsigned r;
        bit v;
        drive32(1, 7, 32'h8000_0000, 32'd31, 9, 1, 0);
        tick;
        vectors++;
        if ({b32.out_valid, b32.alu_result, b32.OVF} !== {1'b1, 32'h0000_0001, 1'b0}) begin
            errors++;
            $display("FAIL w32_shr: got v=%b r=%h ovf=%b expected 1 00000001 0", b32.out_valid, b32.alu_result, b32.OVF);
        end
        drive32(1, 8, 32'h0000_ffff, 32'h0001_0001, 12, 1, 0);
        tick;
        drive32(0, 0, 0, 0, 0, 0, 0);
        while (!b32.out_valid && c < 60) begin
            tick;
            c++;
        end
        vectors++;
        if (c != 32) begin
            errors++;
            $display("FAIL w32_mul_latency: got %0d cycles expected 32", c);
        end
        vectors++;
        if ({b32.alu_result, b32.OVF, b32.destReg_adr_output} !== {32'hffff_ffff, 1'b0, 4'd12}) begin
            errors++;
            $display("FAIL w32_mul: got r=%h ovf=%b dst=%0d expected ffffffff 0 12", b32.alu_result, b32.OVF, b32.destReg_adr_output);
        end
        for (int i = 0; i < 6; i++) begin
            int op = $urandom_range(0, 7);
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            int imm = $urandom_range(0, 2047);
            model(32, op, 64'(a), op == 3 ? 64'(imm) : 64'(b), r, v);
            drive32(1, op, a, b, i, 0, imm);
            tick;
            vectors++;
            if ({b32.out_valid, b32.alu_result, b32.OVF} !== {1'b1, r[31:0], v}) begin
                errors++;
                $display("FAIL w32_op[%0d] op=%0d: got v=%b r=%h ovf=%b expected 1 %h %b",
                         i, op, b32.out_valid, b32.alu_result, b32.OVF, r[31:0], v);
            end
        end
        drive32(0, 0, 0, 0, 0, 0, 0);
        tick;
    endtask

    initial begin
        drive16(0, 0, 0, 0, 0, 0, 0);
        drive32(0, 0, 0, 0, 0, 0, 0);
        b16.enable = 1'b1;
        b16.out_ready = 1'b1;
        b32.enable = 1'b1;
        b32.out_ready = 1'b1;
        test_reset;
        test_add_ovf;
        test_addi;
        test_back_to_back;
        test_back_pressure;
        test_stall_full;
        test_mul_stall;
        test_reset_mid_mul;
        test_random;
        test_wide;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Parametrised successor of the 16-bit ALU pipeline stage. Registers one decoded instruction (operands, opcode, destination, write-enable, immediate fields), selects register or immediate B operand, and executes it. Adds a valid/ready handshake with back-pressure, a stall input, and a multi-cycle iterative multiply. Sits between decode/register-read and writeback.

## Interface
- `WIDTH`, default 16: data path width.
- `ADR_W`, default 3: register address width.
- `COP_W`, default 4: opcode width; must be ≥ 4.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: global stall; when 0, no accept, no state change, multiply counter frozen.
- `in_valid`, input, 1: instruction present.
- `in_ready`, output, 1: stage accepts this cycle.
- `regA`, `regB`, input, WIDTH: register operands.
- `cop`, input, COP_W: opcode.
- `destReg_adr`, input, ADR_W: destination register.
- `we`, input, 1: writeback enable.
- `regA_adr`, `regB_adr`, input, ADR_W: source address fields, reused as immediate bits.
- `inst_freeBits`, input, 3: immediate low bits.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer takes result.
- `alu_result`, output, WIDTH: result.
- `OVF`, output, 1: overflow flag.
- `destReg_adr_output`, output, ADR_W: forwarded destination.
- `we_output`, output, 1: forwarded write-enable, qualified by `out_valid`.

## Operation
- Immediate: IMM = zero-extend of {regA_adr, regB_adr, inst_freeBits}, 2·ADR_W+3 bits, to WIDTH. If 2·ADR_W+3 > WIDTH, keep the low WIDTH bits.
- Opcodes (low 4 bits; any higher bit set → PASS A, OVF=0):
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0011 ADDI (A+IMM)
  - 0100 OR
  - 0101 XOR
  - 0110 SHL (A<<B[log2 WIDTH−1:0])
  - 0111 SHR logical
  - 1000 MUL (low WIDTH bits of unsigned A·B)
  - others PASS A
- OVF rules:
  - ADD, SUB, ADDI: signed two's-complement overflow.
  - MUL: 1 iff high WIDTH bits of the 2·WIDTH product ≠ 0.
  - All other opcodes: 0.
- States:
  - EMPTY: no result held.
  - FULL: result held, `out_valid`=1.
  - MUL_BUSY: iterating.
- Accept condition: `in_ready` = `enable` & state≠MUL_BUSY & (state==EMPTY | `out_ready`).
- Accept of a non-MUL instruction → FULL with the registered result.
- Accept of MUL → MUL_BUSY, counter=WIDTH. One shift-add step per enabled cycle. When the counter reaches 0 → FULL.
- FULL & `out_ready` & no accept → EMPTY. FULL & `out_ready` & accept → stays FULL with the new instruction (back-to-back).
- Outputs hold stable while `out_valid` & !`out_ready`.

## Timing
- Reset: state EMPTY. `out_valid`, `alu_result`, `OVF`, `destReg_adr_output`, `we_output` all 0. Multiply counter 0.
- `in_ready` during reset is 0. A reset asserted mid-multiply aborts the multiply; no result is emitted.
- Single-cycle ops: accepted at edge N → `out_valid`=1 after edge N; result computed combinationally from the held operands.
- MUL: accepted at edge N → `out_valid`=1 after edge N+WIDTH when `enable` is held high. Each cycle with `enable`=0 adds one cycle.
- `enable`=0 while FULL: `out_valid` stays 1. A transfer still completes when `out_ready`=1 (a dequeue is not a state change of the held data) and the stage goes EMPTY. Only accepts are blocked.
- Throughput: 1 instruction/cycle for non-MUL when `out_ready` is held high. MUL: 1 per WIDTH+1 cycles.

## Structure
- Package `alu_pkg`:
  - cop localparams (COP_ADD … COP_MUL).
  - state enum (EMPTY, FULL, MUL_BUSY).
  - function `is_mul(cop)`.
- Sub-module `mul_iter`, parametrised WIDTH: shift-add multiplier.
  - Ports: `start`, `step_en`, operands, 2·WIDTH `product`, `done`.
  - Async reset.
- The combinational ALU and the immediate mux live in the top module.

## Test plan
- Reset mid-MUL: assert `reset` during MUL_BUSY → all outputs 0 immediately, `in_ready`=0 while `reset` is high. After release, state EMPTY with no spurious `out_valid`.
- ADD overflow: ADD 0x7FFF+0x0001 with WIDTH=16 → `alu_result`=0x8000, OVF=1, `out_valid` one cycle after accept. `destReg_adr_output` and `we_output` match the input values.
- ADDI immediate: ADDI, regA=0x0010, regA_adr=3'b101, regB_adr=3'b010, free=3'b111 → IMM=0x0157, result 0x0167, OVF=0.
- Back-pressure: 3 ADDs back-to-back with `out_ready` low for 4 cycles →
  - first result held stable;
  - `in_ready`=0 after the first accept;
  - all 3 results emitted in order once `out_ready` rises;
  - none lost or duplicated.
- MUL timing: MUL 0x0100·0x0100 (WIDTH=16) with `enable` dropped for 2 cycles mid-iteration → result 0x0000, OVF=1, `out_valid` at accept+16+2 cycles. `in_ready`=0 throughout.
- WIDTH=32, ADR_W=4 build: SHR 0x80000000 by 31 → 0x00000001. MUL 0x0000FFFF·0x00010001 → 0xFFFFFFFF, OVF=0.
